// File: rtl/led_pkg.sv
// Shared definitions for the LED indicator channels: FSM state encoding,
// pin polarity and default timing for a 50 MHz system clock.
package led_pkg;

   // Per-channel sequencer state.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } ledState_t;

   // Board LED pins are inverted: driving 0 lights the LED.
   localparam logic LED_ON  = 1'b0;
   localparam logic LED_OFF = 1'b1;

   // 100 ms at 50 MHz, used for both the lit and the dark phase by default.
   localparam int CYC_100MS     = 5_000_000;
   localparam int BLINK_DEFAULT = 3;

endpackage : led_pkg

// File: rtl/led_blink.sv
// One LED channel: turns a single-cycle event pulse into BLINK_CNT ON/OFF
// pairs. The FSM, both counters and the LED/busy outputs all live here.
module led_blink
   import led_pkg::*;
#(
   parameter int ON_CYC    = CYC_100MS,
   parameter int OFF_CYC   = CYC_100MS,
   parameter int BLINK_CNT = BLINK_DEFAULT
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic iEvt,
   output logic oLed,
   output logic oBusy
);

   localparam int PHASE_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
   localparam int BLINK_W   = $clog2(BLINK_CNT + 1);

   // A zero-length phase or zero blinks has no meaningful behaviour.
   if (ON_CYC < 1 || OFF_CYC < 1 || BLINK_CNT < 1) begin : gBadParams
      $error("led_blink: ON_CYC, OFF_CYC and BLINK_CNT must all be >= 1");
   end

   localparam logic [PHASE_W-1:0] ON_LAST   = PHASE_W'(ON_CYC - 1);
   localparam logic [PHASE_W-1:0] OFF_LAST  = PHASE_W'(OFF_CYC - 1);
   localparam logic [BLINK_W-1:0] BLINK_END = BLINK_W'(BLINK_CNT);

   ledState_t            stateReg, stateNext;
   logic [PHASE_W-1:0]   phaseReg, phaseNext;
   logic [BLINK_W-1:0]   blinkReg, blinkNext;
   logic [BLINK_W-1:0]   blinkInc;

   // blinkReg is always below BLINK_CNT, so the increment cannot overflow.
   assign blinkInc = blinkReg + 1'b1;

   // Next-state logic; an event restarts from any state and wins over the
   // terminal OFF->IDLE transition so busy never drops between sequences.
   always_comb begin
      stateNext = stateReg;
      phaseNext = phaseReg;
      blinkNext = blinkReg;
      if (iEvt) begin
         stateNext = ON;
         phaseNext = '0;
         blinkNext = '0;
      end else begin
         case (stateReg)
            IDLE: ;
            ON: begin
               if (phaseReg == ON_LAST) begin
                  stateNext = OFF;
                  phaseNext = '0;
               end else begin
                  phaseNext = phaseReg + 1'b1;
               end
            end
            OFF: begin
               if (phaseReg == OFF_LAST) begin
                  phaseNext = '0;
                  if (blinkInc == BLINK_END) begin
                     stateNext = IDLE;
                     blinkNext = '0;
                  end else begin
                     stateNext = ON;
                     blinkNext = blinkInc;
                  end
               end else begin
                  phaseNext = phaseReg + 1'b1;
               end
            end
            default: begin
               stateNext = IDLE;
               phaseNext = '0;
               blinkNext = '0;
            end
         endcase
      end
   end

   // State, counters and outputs; outputs are decoded from the next state so
   // the LED lights right after the edge that samples the event.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         stateReg <= IDLE;
         phaseReg <= '0;
         blinkReg <= '0;
         oLed     <= LED_OFF;
         oBusy    <= 1'b0;
      end else begin
         stateReg <= stateNext;
         phaseReg <= phaseNext;
         blinkReg <= blinkNext;
         oLed     <= (stateNext == ON) ? LED_ON : LED_OFF;
         oBusy    <= (stateNext != IDLE);
      end
   end

endmodule : led_blink

// File: rtl/led_indicator.sv
// Three independent LED blink channels, one per user key / status event.
module led_indicator
   import led_pkg::*;
#(
   parameter int ON_CYC    = CYC_100MS,
   parameter int OFF_CYC   = CYC_100MS,
   parameter int BLINK_CNT = BLINK_DEFAULT
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic iEvt1,
   input  logic iEvt2,
   input  logic iEvt3,
   output logic oLed1,
   output logic oLed2,
   output logic oLed3,
   output logic oBusy1,
   output logic oBusy2,
   output logic oBusy3
);

   logic [2:0] evtVec;
   logic [2:0] ledVec;
   logic [2:0] busyVec;

   assign evtVec = {iEvt3, iEvt2, iEvt1};

   // One channel instance per event input; no state is shared between them.
   for (genvar gi = 0; gi < 3; gi++) begin : gChan
      led_blink #(
         .ON_CYC    (ON_CYC),
         .OFF_CYC   (OFF_CYC),
         .BLINK_CNT (BLINK_CNT)
      ) uBlink (
         .sys_clk   (sys_clk),
         .sys_rst_n (sys_rst_n),
         .iEvt      (evtVec[gi]),
         .oLed      (ledVec[gi]),
         .oBusy     (busyVec[gi])
      );
   end

   assign {oLed3, oLed2, oLed1}    = ledVec;
   assign {oBusy3, oBusy2, oBusy1} = busyVec;

endmodule : led_indicator
